// File: rtl/execute_muldiv.sv
// RV32M execute unit: MUL/MULH/MULHSU/MULHU via an iterative shift-add or a
// single-cycle registered product, DIV/DIVU/REM/REMU via iterative restoring division.
module execute_muldiv #(
   parameter int XLEN     = 32,
   parameter int FAST_MUL = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [1:0]        op_q;
   logic              neg_q;
   logic              rem_neg_q;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   dvs;
   logic [XLEN-1:0]   result;

   // Operand decode on the request inputs, used only on the accept edge.
   logic              a_signed, b_signed, a_neg, b_neg;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;
   logic [2*XLEN-1:0] fast_prod;

   always_comb begin
      a_signed    = (funct3_i == 3'b001) || (funct3_i == 3'b010) || (funct3_i[2] && !funct3_i[0]);
      b_signed    = (funct3_i == 3'b001) || (funct3_i[2] && !funct3_i[0]);
      a_neg       = a_signed && rs1_i[XLEN-1];
      b_neg       = b_signed && rs2_i[XLEN-1];
      a_mag       = a_neg ? -rs1_i : rs1_i;
      b_mag       = b_neg ? -rs2_i : rs2_i;
      div_zero    = (rs2_i == '0);
      div_ovf     = !funct3_i[0] && (rs1_i == MOST_NEG) && (rs2_i == '1);
      if (div_zero)
         special_res = funct3_i[1] ? rs1_i : '1;
      else
         special_res = funct3_i[1] ? '0 : MOST_NEG;
      fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
   end

   function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                                input logic              neg,
                                                input logic [1:0]        op);
      logic [2*XLEN-1:0] p;
      p = neg ? -mag : mag;
      return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   endfunction

   // One shift-add step and one restoring-division step, from current state.
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN:0]     div_shift, div_trial;
   logic [XLEN-1:0]   rem_next, quo_next, quo_fix, rem_fix;

   always_comb begin
      acc_next  = mplier[0] ? acc + mcand : acc;
      div_shift = {rem, quo[XLEN-1]};
      div_trial = div_shift - {1'b0, dvs};
      if (div_trial[XLEN]) begin
         rem_next = div_shift[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end else begin
         rem_next = div_trial[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b1};
      end
      quo_fix = neg_q     ? -quo_next : quo_next;
      rem_fix = rem_neg_q ? -rem_next : rem_next;
   end

   // NOTE: nonblocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         result    <= '0;
      end else if (kill_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  op_q      <= funct3_i[1:0];
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  cnt       <= CW'(XLEN);
                  if (funct3_i[2]) begin
                     if (div_zero || div_ovf) begin
                        result <= special_res;
                        state  <= DONE;
                     end else begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        state <= DIV;
                     end
                  end else if (FAST_MUL != 0) begin
                     result <= mul_pick(fast_prod, a_neg ^ b_neg, funct3_i[1:0]);
                     state  <= DONE;
                  end else begin
                     acc    <= '0;
                     mcand  <= {{XLEN{1'b0}}, a_mag};
                     mplier <= b_mag;
                     state  <= MUL;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result <= mul_pick(acc_next, neg_q, op_q);
                  state  <= DONE;
               end
            end
            DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result <= op_q[1] ? rem_fix : quo_fix;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (ready_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready_o  = (state == IDLE);
   assign valid_o  = (state == DONE);
   assign busy_o   = (state != IDLE);
   assign result_o = result;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: an iterative and a fast-multiply instance checked every
// cycle against a latency/result model, plus directed literal cases and aborts.
module tb_execute_muldiv;

   localparam logic [31:0] MIN = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i [2];
   logic        kill_i  [2];
   logic        ready_i [2];
   logic [2:0]  funct3_i[2];
   logic [31:0] rs1_i   [2];
   logic [31:0] rs2_i   [2];
   logic        ready_o [2];
   logic        valid_o [2];
   logic        busy_o  [2];
   logic [31:0] result_o[2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   execute_muldiv #(.XLEN(32), .FAST_MUL(0)) dut_iter (
      .clk(clk), .reset(reset), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
      .funct3_i(funct3_i[0]), .rs1_i(rs1_i[0]), .rs2_i(rs2_i[0]), .kill_i(kill_i[0]),
      .valid_o(valid_o[0]), .ready_i(ready_i[0]), .result_o(result_o[0]), .busy_o(busy_o[0])
   );

   execute_muldiv #(.XLEN(32), .FAST_MUL(1)) dut_fast (
      .clk(clk), .reset(reset), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
      .funct3_i(funct3_i[1]), .rs1_i(rs1_i[1]), .rs2_i(rs2_i[1]), .kill_i(kill_i[1]),
      .valid_o(valid_o[1]), .ready_i(ready_i[1]), .result_o(result_o[1]), .busy_o(busy_o[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural result of an RV32M op, from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
            p = sa / sb; return p[31:0];
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Edges from accept (counted as the first) to the first valid_o cycle.
   function automatic int lat_of(input int d, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
      if (!f[2] && d == 1) return 1;
      return 33;
   endfunction

   typedef enum int {M_IDLE, M_BUSY, M_DONE} mmode_t;
   mmode_t      m_mode[2];
   int          m_left[2];
   logic [31:0] m_res [2];

   always @(posedge clk or posedge reset) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_mode[d] <= M_IDLE;
         end else if (kill_i[d]) begin
            m_mode[d] <= M_IDLE;
         end else begin
            case (m_mode[d])
               M_IDLE: if (valid_i[d]) begin
                  m_res[d] <= ref_op(funct3_i[d], rs1_i[d], rs2_i[d]);
                  if (lat_of(d, funct3_i[d], rs1_i[d], rs2_i[d]) == 1) begin
                     m_mode[d] <= M_DONE;
                  end else begin
                     m_mode[d] <= M_BUSY;
                     m_left[d] <= lat_of(d, funct3_i[d], rs1_i[d], rs2_i[d]) - 1;
                  end
               end
               M_BUSY: begin
                  m_left[d] <= m_left[d] - 1;
                  if (m_left[d] == 1) m_mode[d] <= M_DONE;
               end
               default: if (ready_i[d]) m_mode[d] <= M_IDLE;
            endcase
         end
      end
   end

   bit compare_en = 1'b0;

   always @(negedge clk) begin
      if (compare_en && !reset) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("cyc valid_o[%0d]", d), 32'(valid_o[d]), 32'(m_mode[d] == M_DONE));
            check($sformatf("cyc ready_o[%0d]", d), 32'(ready_o[d]), 32'(m_mode[d] == M_IDLE));
            check($sformatf("cyc busy_o[%0d]", d), 32'(busy_o[d]), 32'(m_mode[d] != M_IDLE));
            if (m_mode[d] == M_DONE)
               check($sformatf("cyc result_o[%0d]", d), result_o[d], m_res[d]);
         end
      end
   end

   task automatic run_op(input int d, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit has_lit, input logic [31:0] lit,
                         input int hold);
      int          lat;
      logic [31:0] held;
      logic [31:0] exp;
      string       tag;
      exp = ref_op(f, a, b);
      tag = $sformatf("d%0d f%0d %h,%h", d, f, a, b);
      if (has_lit) check({tag, " model"}, exp, lit);
      @(negedge clk);
      valid_i[d]  = 1'b1;
      funct3_i[d] = f;
      rs1_i[d]    = a;
      rs2_i[d]    = b;
      @(posedge clk);
      @(negedge clk);
      valid_i[d]  = 1'b0;
      funct3_i[d] = 3'($urandom);
      rs1_i[d]    = $urandom;
      rs2_i[d]    = $urandom;
      lat = 1;
      while (!valid_o[d] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(lat_of(d, f, a, b)));
      check({tag, " result"}, result_o[d], has_lit ? lit : exp);
      held = result_o[d];
      repeat (hold) begin
         @(negedge clk);
         check({tag, " held result"}, result_o[d], held);
         check({tag, " held valid"}, 32'(valid_o[d]), 32'd1);
      end
      ready_i[d] = 1'b1;
      @(negedge clk);
      ready_i[d] = 1'b0;
      check({tag, " ready after handshake"}, 32'(ready_o[d]), 32'd1);
      check({tag, " valid after handshake"}, 32'(valid_o[d]), 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return MIN;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         valid_i[d]  = 1'b0;
         kill_i[d]   = 1'b0;
         ready_i[d]  = 1'b0;
         funct3_i[d] = 3'b000;
         rs1_i[d]    = '0;
         rs2_i[d]    = '0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset valid_o[%0d]", d), 32'(valid_o[d]), 32'd0);
         check($sformatf("reset ready_o[%0d]", d), 32'(ready_o[d]), 32'd1);
         check($sformatf("reset busy_o[%0d]", d), 32'(busy_o[d]), 32'd0);
         check($sformatf("reset result_o[%0d]", d), result_o[d], 32'd0);
      end
      reset = 1'b0;
      compare_en = 1'b1;

      run_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 0);
      run_op(0, 3'b011, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'h0000_0006, 0);
      run_op(0, 3'b001, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 0);
      run_op(0, 3'b010, MIN, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
      run_op(1, 3'b010, MIN, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0);
      run_op(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 0);
      run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 0);
      run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 0);
      run_op(0, 3'b101, 32'd100, 32'd7, 1'b1, 32'd14, 5);
      run_op(1, 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 0);
      run_op(0, 3'b100, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 0);
      run_op(0, 3'b111, 32'd5, 32'd0, 1'b1, 32'd5, 0);
      run_op(1, 3'b100, MIN, 32'hFFFF_FFFF, 1'b1, MIN, 0);
      run_op(0, 3'b110, MIN, 32'hFFFF_FFFF, 1'b1, 32'd0, 2);

      // Kill a divide around its tenth iteration.
      @(negedge clk);
      valid_i[0] = 1'b1; funct3_i[0] = 3'b100; rs1_i[0] = 32'd1000; rs2_i[0] = 32'd3;
      @(posedge clk);
      @(negedge clk);
      valid_i[0] = 1'b0;
      repeat (9) @(negedge clk);
      kill_i[0] = 1'b1;
      @(negedge clk);
      kill_i[0] = 1'b0;
      check("kill busy_o", 32'(busy_o[0]), 32'd0);
      check("kill valid_o", 32'(valid_o[0]), 32'd0);
      check("kill ready_o", 32'(ready_o[0]), 32'd1);
      repeat (40) @(negedge clk);
      check("kill no late valid_o", 32'(valid_o[0]), 32'd0);

      // Asynchronous reset in the middle of an iterative multiply.
      @(negedge clk);
      valid_i[0] = 1'b1; funct3_i[0] = 3'b000; rs1_i[0] = 32'd12345; rs2_i[0] = 32'd678;
      @(posedge clk);
      @(negedge clk);
      valid_i[0] = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset valid_o", 32'(valid_o[0]), 32'd0);
      check("async reset busy_o", 32'(busy_o[0]), 32'd0);
      check("async reset ready_o", 32'(ready_o[0]), 32'd1);
      check("async reset result_o", result_o[0], 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 60; i++) begin
         run_op(int'($urandom_range(0, 1)), 3'($urandom), pick_operand(), pick_operand(),
                1'b0, 32'd0, int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
